// File: rtl/hwpe_stream_addressgen_nd_if.sv
// hwpe_stream_addressgen_nd_if: address/strobe stream between the generator and a streamer
//   addr     word-aligned address
//   strb     byte strobe for the current address
//   valid    addr/strb/dim_last are valid
//   ready    consumer accepts the current address
//   dim_last bit k set when dims 0..k are all on their last iteration
interface hwpe_stream_addressgen_nd_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STEP       = 4,
  parameter int unsigned NB_DIMS    = 3
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic [STEP-1:0]       strb;
  logic                  valid;
  logic                  ready;
  logic [NB_DIMS-1:0]    dim_last;
  modport master (output addr, strb, valid, dim_last, input ready);
  modport slave  (input addr, strb, valid, dim_last, output ready);
endinterface

// File: rtl/hwpe_stream_addressgen_nd.sv
// hwpe_stream_addressgen_nd: N-dimensional nested-loop address generator with valid/ready output
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        synchronous return to IDLE, wipes counters and latched config
//   start_i        starts a run when IDLE
//   base_addr_i    byte base address
//   len_m1_i       per-dim iteration count minus 1, slice k = dim k
//   stride_i       per-dim signed byte stride, slice k = dim k
//   busy_o         high while addresses are being emitted
//   done_o         one-cycle pulse after the final handshake
//   addr_if        address/strobe/dim_last stream (master)
module hwpe_stream_addressgen_nd #(
  parameter int unsigned NB_DIMS    = 3,
  parameter int unsigned CNT        = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STEP       = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [NB_DIMS*CNT-1:0]        len_m1_i,
  input  logic [NB_DIMS*ADDR_WIDTH-1:0] stride_i,
  output logic                          busy_o,
  output logic                          done_o,
  hwpe_stream_addressgen_nd_if.master   addr_if
);
  localparam int unsigned LSB = $clog2(STEP);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                        state_q, state_d;
  logic [CNT-1:0]                cnt_q [NB_DIMS];
  logic [CNT-1:0]                cnt_d [NB_DIMS];
  logic [ADDR_WIDTH-1:0]         off_q [NB_DIMS];
  logic [ADDR_WIDTH-1:0]         off_d [NB_DIMS];
  logic [ADDR_WIDTH-1:0]         base_q, base_d;
  logic [NB_DIMS*CNT-1:0]        len_q, len_d;
  logic [NB_DIMS*ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]         byte_addr;
  logic [NB_DIMS-1:0]            dim_last;
  logic                          valid;
  logic                          hs;
  logic                          launch;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      cnt_q    <= '{default: '0};
      off_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
    end
  end
  always_comb begin
    state_d = clear_i                                           ? IDLE :
              (state_q == IDLE && start_i)                      ? RUN  :
              (state_q == RUN && hs && dim_last[NB_DIMS-1])     ? DONE :
              (state_q == DONE)                                 ? IDLE : state_q;
  end
  always_comb begin
    valid  = state_q == RUN;
    busy_o = valid;
    done_o = state_q == DONE;
  end
  assign hs     = valid & addr_if.ready;
  assign launch = state_q == IDLE && start_i;
  // dim_last[k] is a running AND of per-dim "at last iteration" flags
  always_comb begin
    logic acc;
    acc      = 1'b1;
    dim_last = '0;
    for (int k = 0; k < NB_DIMS; k++) begin
      acc         = acc & (cnt_q[k] == len_q[k*CNT +: CNT]);
      dim_last[k] = acc;
    end
  end
  // Odometer advance: dims below the first non-exhausted one restart at 0,
  // that dim steps by its stride, outer dims hold. The final handshake wraps
  // every dim, which leaves all counters and offsets zeroed for DONE.
  always_comb begin
    logic carry;
    base_d   = base_q;
    len_d    = len_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    carry    = 1'b1;
    if (clear_i) begin
      base_d   = '0;
      len_d    = '0;
      stride_d = '0;
      cnt_d    = '{default: '0};
      off_d    = '{default: '0};
    end else if (launch) begin
      base_d   = base_addr_i;
      len_d    = len_m1_i;
      stride_d = stride_i;
      cnt_d    = '{default: '0};
      off_d    = '{default: '0};
    end else if (hs) begin
      for (int k = 0; k < NB_DIMS; k++) begin
        if (carry) begin
          if (cnt_q[k] == len_q[k*CNT +: CNT]) begin
            cnt_d[k] = '0;
            off_d[k] = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT'(1);
            off_d[k] = off_q[k] + stride_q[k*ADDR_WIDTH +: ADDR_WIDTH];
            carry    = 1'b0;
          end
        end
      end
    end
  end
  always_comb begin
    byte_addr = base_q;
    for (int k = 0; k < NB_DIMS; k++) byte_addr = byte_addr + off_q[k];
  end
  assign addr_if.addr     = {byte_addr[ADDR_WIDTH-1:LSB], LSB'(0)};
  assign addr_if.strb     = {STEP{1'b1}} << byte_addr[LSB-1:0];
  assign addr_if.valid    = valid;
  assign addr_if.dim_last = dim_last;
endmodule

// File: doc/hwpe_stream_addressgen_nd.md
Name: hwpe_stream_addressgen_nd

Overview:
N-dimensional streaming address generator. It is the parametrised successor of the fixed 3-loop word/line/feature generator: dimension count and counter width are generic. Addresses are emitted over a valid/ready handshake instead of a free-running enable, so the TCDM/streamer side can back-pressure. The block sits between the HWPE controller (configuration, start/done) and a source or sink streamer (address and strobe consumer).

Parameters:
NB_DIMS, 3, number of nested loop dimensions; dim 0 is innermost; must be >= 1.
CNT, 16, width of each per-dimension counter and length field.
ADDR_WIDTH, 32, address and offset width.
STEP, 4, bytes per bus word; must be a power of 2 and >= 2.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
clear_i  in  1  synchronous clear to IDLE.
start_i  in  1  start pulse; sampled only in IDLE.
base_addr_i  in  ADDR_WIDTH  byte base address; latched at start.
len_m1_i  in  NB_DIMS*CNT  per-dimension iteration count minus 1; slice k = dim k; latched at start.
stride_i  in  NB_DIMS*ADDR_WIDTH  per-dimension signed byte stride; latched at start.
addr_o  in/out: out  ADDR_WIDTH  word-aligned address, low log2(STEP) bits forced to 0.
strb_o  out  STEP  byte strobe, all ones shifted left by the byte offset.
addr_valid_o  out  1  addr_o and strb_o are valid.
addr_ready_i  in  1  consumer accepts the current address.
dim_last_o  out  NB_DIMS  bit k = 1 iff counters of dims 0..k are all at len_m1 for the current address.
busy_o  out  1  high in RUN.
done_o  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset is asynchronous on rst_ni low.
  - State goes to IDLE; all counters, offset registers and latched config go to 0.
  - Output values under reset: addr_valid_o=0, busy_o=0, done_o=0, addr_o=0, strb_o='1, dim_last_o='1.
- clear_i has the same effect synchronously and has priority over every other input, including mid-RUN. No done_o is generated on clear.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i. The config is latched, counters cnt[k]=0 and offsets off[k]=0.
  - start_i is ignored in RUN and DONE.
  - RUN -> DONE on a handshake (addr_valid_o & addr_ready_i) while dim_last_o[NB_DIMS-1]=1.
  - DONE -> IDLE unconditionally after 1 cycle; done_o=1 only in DONE.
- addr_valid_o = (state==RUN). There is no combinational path from addr_ready_i to any output.
- Address arithmetic:
  - Byte address A = base + sum of off[k], modulo 2^ADDR_WIDTH.
  - stride_i slices are two's complement; wrap-around is silent.
  - addr_o = A with its low log2(STEP) bits cleared.
  - strb_o = {STEP{1}} << A[log2(STEP)-1:0].
- Advance on each handshake in RUN. Let d be the lowest dim with cnt[d] < len_m1[d]:
  - cnt[d]++ and off[d] += stride[d];
  - for all k<d: cnt[k]=0 and off[k]=0;
  - for all k>d: unchanged.
  - If no such d exists, this is the final handshake; counters and offsets are zeroed on entry to DONE.
- Stride semantics: stride[k] is the byte jump between consecutive iterations of dim k, measured from the start of that iteration. Inner offsets restart from 0 on each outer step.
- Total addresses emitted = product of (len_m1[k]+1). With all len_m1=0, exactly one address (base) is emitted.
- Back-pressure: while addr_valid_o=1 and addr_ready_i=0, addr_o, strb_o and dim_last_o hold stable.
- Minimum start-to-start period is total+2 cycles: RUN for total cycles at full throughput, plus DONE, plus IDLE.
- Config inputs may change freely after start without affecting the current run.

Test Plan:
1. NB_DIMS=2, base=0x100, len_m1={1,2} (dim0=2, dim1=1), stride={16,4}, ready=1 -> addr 0x100,0x104,0x108,0x110,0x114,0x118 on consecutive cycles; dim_last_o[0] high on 0x108 and 0x118; dim_last_o[1] high only on 0x118; done_o pulse 1 cycle after.
2. Same config, addr_ready_i toggling 1,0,0,1,... -> identical address sequence; outputs stable during stalls; exactly 6 handshakes, then done_o.
3. NB_DIMS=3, base=0x1000, stride0=4, stride1=-64, stride2=0x400, len_m1 all 1 -> 0x1000,0x1004,0xFC0,0xFC4,0x1400,0x1404,0x13C0,0x13C4.
4. base=0x103, all len_m1=0 -> single address 0x100 with strb_o=4'b1000; done_o two cycles after start.
5. clear_i asserted mid-run after 3 handshakes -> next cycle addr_valid_o=0, busy_o=0, no done_o; a new start restarts at base.
6. start_i pulsed during RUN with different base -> ignored; sequence continues with the original config.
